// File: rtl/pico_mips_pkg.sv
// Shared types and fixed-point constants for the pico_mips affine datapath.
// Coefficients and offsets are Q2 (scaled by 4).
package pico_mips_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 12;

  typedef enum logic [2:0] {
    WAIT_X,
    WAIT_X_REL,
    WAIT_Y,
    WAIT_Y_REL,
    CALC_X,
    CALC_Y,
    SHOW_X,
    SHOW_Y
  } state_t;

  localparam logic signed [ACC_W-1:0] K_075 = 12'sd3;
  localparam logic signed [ACC_W-1:0] K_05  = 12'sd2;
  localparam logic signed [ACC_W-1:0] OFS_X = 12'sd80;
  localparam logic signed [ACC_W-1:0] OFS_Y = -12'sd80;

endpackage

// File: rtl/pico_mips_alu.sv
// Combinational signed multiply-accumulate: (a*x + b*y + ofs) >>> 2,
// truncated to DATA_W bits (floor, wraps, no saturation).
module pico_mips_alu
  import pico_mips_pkg::*;
(
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [ACC_W-1:0]  b,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic signed [ACC_W-1:0]  ofs,
  output logic [DATA_W-1:0]        result
);

  logic signed [ACC_W-1:0] xe;
  logic signed [ACC_W-1:0] ye;
  logic signed [ACC_W-1:0] acc;
  logic                    unused_bits;

  assign xe  = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
  assign ye  = {{(ACC_W-DATA_W){y[DATA_W-1]}}, y};
  assign acc = a * xe + b * ye + ofs;

  // Dropping the two Q2 fraction bits of a two's-complement value floors it.
  assign result = acc[DATA_W+1:2];

  assign unused_bits = ^{acc[ACC_W-1:DATA_W+2], acc[1:0]};

endmodule

// File: rtl/pico_mips.sv
// pico_mips top: strobe-sequenced 2-D affine transform, switches in, LEDs out.
// Optional PICO_MIPS_SW_SYNC_EN adds a 2-flop synchroniser on SW[8:0].
module pico_mips
  import pico_mips_pkg::*;
(
  input  logic       Clock,
  input  logic [9:0] SW,
  output logic [7:0] LED
);

  logic       rst;
  logic [8:0] sw_s;
  logic       stb;
  logic [7:0] din;

  assign rst = ~SW[9];

`ifdef PICO_MIPS_SW_SYNC_EN
  logic [8:0] sync1_q;
  logic [8:0] sync2_q;

  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SW[8:0];
      sync2_q <= sync1_q;
    end
  end

  assign sw_s = sync2_q;
`else
  assign sw_s = SW[8:0];
`endif

  assign stb = sw_s[8];
  assign din = sw_s[7:0];

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] x2_q, x2_d;
  logic [7:0] y2_q, y2_d;
  logic [7:0] led_q, led_d;

  logic signed [ACC_W-1:0] alu_a;
  logic signed [ACC_W-1:0] alu_b;
  logic signed [ACC_W-1:0] alu_ofs;
  logic [DATA_W-1:0]       alu_res;

  // One ALU serves both outputs; CALC_Y selects the y-row coefficients.
  always_comb begin
    alu_a   = K_075;
    alu_b   = K_05;
    alu_ofs = OFS_X;
    if (state_q == CALC_Y) begin
      alu_a   = -K_05;
      alu_b   = K_075;
      alu_ofs = OFS_Y;
    end
  end

  pico_mips_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .x      (x_q),
    .y      (y_q),
    .ofs    (alu_ofs),
    .result (alu_res)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
    led_d   = led_q;
    unique case (state_q)
      WAIT_X: begin
        if (stb) begin
          x_d     = din;
          state_d = WAIT_X_REL;
        end
      end
      WAIT_X_REL: if (!stb) state_d = WAIT_Y;
      WAIT_Y: begin
        if (stb) begin
          y_d     = din;
          state_d = WAIT_Y_REL;
        end
      end
      WAIT_Y_REL: if (!stb) state_d = CALC_X;
      CALC_X: begin
        x2_d    = alu_res;
        state_d = CALC_Y;
      end
      CALC_Y: begin
        y2_d    = alu_res;
        state_d = SHOW_X;
      end
      SHOW_X: begin
        led_d = x2_q;
        if (stb) state_d = SHOW_Y;
      end
      SHOW_Y: begin
        led_d = y2_q;
        if (!stb) state_d = WAIT_X;
      end
      default: state_d = WAIT_X;
    endcase
  end

  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_X;
      x_q     <= '0;
      y_q     <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      led_q   <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_pico_mips.sv
// Directed + random bench for pico_mips; works with or without
// PICO_MIPS_SW_SYNC_EN (waits exceed the extra synchroniser latency).
module tb_pico_mips;

  logic       Clock;
  logic [9:0] SW;
  logic [7:0] LED;

  int total;
  int bad;

  pico_mips dut (
    .Clock (Clock),
    .SW    (SW),
    .LED   (LED)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: LED=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input int g);
    SW = {1'b1, 1'b1, v};
    wait_cyc(g);
    SW[8] = 1'b0;
    wait_cyc(g);
  endtask

  task automatic show(input int rd, output logic [7:0] lx,
                      output logic [7:0] ly);
    wait_cyc(rd);
    lx = LED;
    SW[8] = 1'b1;
    wait_cyc(rd);
    ly = LED;
    SW[8] = 1'b0;
  endtask

  task automatic run(input logic [7:0] x, input logic [7:0] y,
                     input int g, input int rd,
                     output logic [7:0] lx, output logic [7:0] ly);
    send(x, g);
    send(y, g);
    show(rd, lx, ly);
    wait_cyc(g);
  endtask

  function automatic logic [7:0] ref_x(input logic [7:0] x,
                                       input logic [7:0] y);
    int  xi, yi, r;
    real v;
    xi = int'($signed(x));
    yi = int'($signed(y));
    v  = $floor(0.75 * xi + 0.5 * yi + 20.0);
    r  = int'(v);
    return r[7:0];
  endfunction

  function automatic logic [7:0] ref_y(input logic [7:0] x,
                                       input logic [7:0] y);
    int  xi, yi, r;
    real v;
    xi = int'($signed(x));
    yi = int'($signed(y));
    v  = $floor(-0.5 * xi + 0.75 * yi - 20.0);
    r  = int'(v);
    return r[7:0];
  endfunction

  initial begin
    logic [7:0] lx, ly;
    logic [7:0] rx, ry;
    total = 0;
    bad   = 0;

    SW = 10'h000;
    wait_cyc(5);
    chk("reset_led", LED, 8'h00);
    SW = 10'h200;
    wait_cyc(20);

    run(8'h00, 8'h00, 20, 40, lx, ly);
    chk("t1_x2", lx, 8'h14);
    chk("t1_y2", ly, 8'hEC);

    send(8'h01, 20);
    chk("hold_led", LED, 8'hEC);
    send(8'h01, 20);
    show(40, lx, ly);
    wait_cyc(20);
    chk("t2_x2", lx, 8'h15);
    chk("t2_y2", ly, 8'hEC);

    run(8'h7F, 8'h7F, 20, 40, lx, ly);
    chk("t3_x2", lx, 8'hB2);
    chk("t3_y2", ly, 8'h0B);

    run(8'h80, 8'h80, 20, 40, lx, ly);
    chk("t4_x2", lx, 8'h74);
    chk("t4_y2", ly, 8'hCC);

    SW = {1'b1, 1'b1, 8'h04};
    wait_cyc(20);
    SW[9] = 1'b0;
    wait_cyc(2);
    chk("abort_led", LED, 8'h00);
    SW = 10'h000;
    wait_cyc(5);
    SW = 10'h200;
    wait_cyc(20);
    run(8'h04, 8'h08, 20, 40, lx, ly);
    chk("t5_x2", lx, 8'h1B);
    chk("t5_y2", ly, 8'hF0);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] rxi, ryi;
      rxi = 8'($urandom_range(0, 255));
      ryi = 8'($urandom_range(0, 255));
      rx = ref_x(rxi, ryi);
      ry = ref_y(rxi, ryi);
      run(rxi, ryi, 4, 6, lx, ly);
      chk("rnd_x2", lx, rx);
      chk("rnd_y2", ly, ry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
